// File: rtl/shift_rows_stream.sv
// Streaming ShiftRows / InvShiftRows / bypass stage with a 2-entry output FIFO.
// Byte (r,c) is the ((4c+r))-th byte counting from the MSB end.
module shift_rows_stream #(
  parameter int NB = 4,
  parameter int W  = 32 * NB
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   in_mode,
  input  logic [W-1:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [1:0]   out_mode,
  output logic [W-1:0] out_state
);

  generate
    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
      $error("shift_rows_stream: NB must be 4, 6 or 8");
    end
  endgenerate

  logic [W-1:0] fwd;
  logic [W-1:0] inv;

  // Rijndael uses wider offsets on rows 2 and 3 for 256-bit blocks
  for (genvar c = 0; c < NB; c++) begin : g_c
    for (genvar r = 0; r < 4; r++) begin : g_r
      localparam int S  = (NB == 8 && r >= 2) ? r + 1 : r;
      localparam int FC = (c + S) % NB;
      localparam int IC = (c + NB - S) % NB;
      localparam int DO = W - 1 - (4 * c + r) * 8;
      localparam int FO = W - 1 - (4 * FC + r) * 8;
      localparam int IO = W - 1 - (4 * IC + r) * 8;
      assign fwd[DO -: 8] = in_state[FO -: 8];
      assign inv[DO -: 8] = in_state[IO -: 8];
    end
  end

  logic [W-1:0] res_d;
  logic [1:0]   mode_d;

  always_comb begin
    res_d  = in_state;
    mode_d = 2'b10;
    unique case (1'b1)
      (in_mode == 2'b00): begin
        res_d  = fwd;
        mode_d = 2'b00;
      end
      (in_mode == 2'b01): begin
        res_d  = inv;
        mode_d = 2'b01;
      end
      default: begin
        res_d  = in_state;
        mode_d = 2'b10;
      end
    endcase
  end

  logic [W-1:0] mem_q [2];
  logic [1:0]   mode_q [2];
  logic         wp_q;
  logic         rp_q;
  logic [1:0]   cnt_q;
  logic [1:0]   cnt_d;
  logic         push;
  logic         pop;

  assign in_ready  = rst_n & (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign out_state = mem_q[rp_q];
  assign out_mode  = mode_q[rp_q];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      (push & ~pop): cnt_d = cnt_q + 2'd1;
      (pop & ~push): cnt_d = cnt_q - 2'd1;
      default:       cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0]  <= '0;
      mem_q[1]  <= '0;
      mode_q[0] <= 2'b00;
      mode_q[1] <= 2'b00;
      wp_q      <= 1'b0;
      rp_q      <= 1'b0;
      cnt_q     <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wp_q]  <= res_d;
        mode_q[wp_q] <= mode_d;
        wp_q         <= ~wp_q;
      end
      if (pop) begin
        rp_q <= ~rp_q;
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_shift_rows_stream.sv
// Directed bench for shift_rows_stream: NB=4 main instance,
// plus NB=8 and NB=6 instances for the wide-block offsets.
module tb_shift_rows_stream;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [1:0]   in_mode, out_mode;
  logic [127:0] in_state, out_state;

  logic         v8, rdy8, ov8, or8;
  logic [1:0]   m8, om8;
  logic [255:0] s8, os8;

  logic         v6, rdy6, ov6, or6;
  logic [1:0]   m6, om6;
  logic [191:0] s6, os6;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  shift_rows_stream #(.NB(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_state(in_state),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mode(out_mode), .out_state(out_state)
  );

  shift_rows_stream #(.NB(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v8), .in_ready(rdy8),
    .in_mode(m8), .in_state(s8),
    .out_valid(ov8), .out_ready(or8),
    .out_mode(om8), .out_state(os8)
  );

  shift_rows_stream #(.NB(6)) dut6 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v6), .in_ready(rdy6),
    .in_mode(m6), .in_state(s6),
    .out_valid(ov6), .out_ready(or6),
    .out_mode(om6), .out_state(os6)
  );

  task automatic chk(input string tag,
                     input logic [255:0] got,
                     input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Reference NB=4 transform written from the row-rotation definition
  function automatic logic [127:0] ref4(input logic [127:0] x,
                                        input logic [1:0] md);
    logic [127:0] y;
    int src;
    y = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (md == 2'b00)      src = (c + r) % 4;
        else if (md == 2'b01) src = (c + 4 - r) % 4;
        else                  src = c;
        y[127-(4*c+r)*8 -: 8] = x[127-(4*src+r)*8 -: 8];
      end
    end
    return y;
  endfunction

  localparam logic [127:0] VIN  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] VOUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

  logic [127:0] eq_s [$];
  logic [1:0]   eq_m [$];
  logic [127:0] rs, ra, rb;
  logic [1:0]   rm;
  logic [255:0] in8, e8;
  logic [191:0] in6, e6;
  int s8t [4];

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_mode = 2'b00; in_state = '0; out_ready = 1'b1;
    v8 = 1'b0; m8 = 2'b00; s8 = '0; or8 = 1'b1;
    v6 = 1'b0; m6 = 2'b00; s6 = '0; or6 = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_state", out_state, 0);
    chk("rst_out_mode", out_mode, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // forward vector, one-cycle latency
    @(negedge clk);
    in_valid = 1'b1; in_mode = 2'b00; in_state = VIN;
    @(negedge clk);
    in_valid = 1'b0;
    chk("fwd_valid", out_valid, 1);
    chk("fwd_state", out_state, VOUT);
    chk("fwd_mode", out_mode, 2'b00);
    @(negedge clk);
    chk("fwd_drained", out_valid, 0);

    // inverse then bypass, back-to-back
    in_valid = 1'b1; in_mode = 2'b01; in_state = VOUT;
    @(negedge clk);
    chk("inv_state", out_state, VIN);
    chk("inv_mode", out_mode, 2'b01);
    in_mode = 2'b10; in_state = VIN;
    @(negedge clk);
    in_valid = 1'b0;
    chk("byp_valid", out_valid, 1);
    chk("byp_state", out_state, VIN);
    chk("byp_mode", out_mode, 2'b10);
    @(negedge clk);
    chk("byp_drained", out_valid, 0);

    // backpressure: two fit, third waits for the first pop
    ra = 128'h00112233445566778899aabbccddeeff;
    rb = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 2'b00; in_state = VIN;
    @(negedge clk);
    chk("bp_ready1", in_ready, 1);
    chk("bp_head1", out_state, VOUT);
    in_mode = 2'b01; in_state = ra;
    @(negedge clk);
    chk("bp_full", in_ready, 0);
    chk("bp_hold1", out_state, VOUT);
    in_mode = 2'b11; in_state = rb;
    @(negedge clk);
    chk("bp_still_full", in_ready, 0);
    chk("bp_hold2", out_state, VOUT);
    chk("bp_hold_mode", out_mode, 2'b00);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_second", out_state, ref4(ra, 2'b01));
    chk("bp_second_mode", out_mode, 2'b01);
    chk("bp_ready_back", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_third", out_state, rb);
    chk("bp_third_mode", out_mode, 2'b10);
    @(negedge clk);
    chk("bp_drained", out_valid, 0);

    // streaming, random modes, no bubbles
    for (int i = 0; i <= 100; i++) begin
      if (i > 0) begin
        chk("str_valid", out_valid, 1);
        chk("str_state", out_state, eq_s.pop_front());
        chk("str_mode", out_mode, eq_m.pop_front());
      end
      if (i < 100) begin
        rs = {$urandom, $urandom, $urandom, $urandom};
        rm = 2'($urandom_range(0, 3));
        in_valid = 1'b1; in_mode = rm; in_state = rs;
        eq_s.push_back(ref4(rs, rm));
        eq_m.push_back(rm == 2'b11 ? 2'b10 : rm);
        if (rm == 2'b00) chk("str_rt", ref4(ref4(rs, 2'b00), 2'b01), rs);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("str_drained", out_valid, 0);

    // asynchronous reset with the FIFO full
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 2'b00; in_state = VIN;
    @(negedge clk);
    in_state = ra;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rr_full", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rr_valid", out_valid, 0);
    chk("rr_state", out_state, 0);
    chk("rr_mode", out_mode, 0);
    chk("rr_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("rr_ready_back", in_ready, 1);
    @(negedge clk);
    chk("rr_no_stale", out_valid, 0);
    chk("rr_state0", out_state, 0);

    // NB=8: offsets 0,1,3,4
    s8t[0] = 0; s8t[1] = 1; s8t[2] = 3; s8t[3] = 4;
    for (int c = 0; c < 8; c++)
      for (int r = 0; r < 4; r++) begin
        in8[255-(4*c+r)*8 -: 8] = 8'(8*r + c);
        e8[255-(4*c+r)*8 -: 8]  = 8'(8*r + (c + s8t[r]) % 8);
      end
    v8 = 1'b1; m8 = 2'b00; s8 = in8;
    @(negedge clk);
    chk("nb8_valid", ov8, 1);
    chk("nb8_fwd", os8, e8);
    chk("nb8_row2_c0", os8[255-2*8 -: 8], 8'd19);
    chk("nb8_row3_c0", os8[255-3*8 -: 8], 8'd28);
    m8 = 2'b01; s8 = e8;
    @(negedge clk);
    v8 = 1'b0;
    chk("nb8_inv", os8, in8);
    chk("nb8_inv_mode", om8, 2'b01);

    // NB=6: offsets 0,1,2,3
    for (int c = 0; c < 6; c++)
      for (int r = 0; r < 4; r++) begin
        in6[191-(4*c+r)*8 -: 8] = 8'(8*r + c);
        e6[191-(4*c+r)*8 -: 8]  = 8'(8*r + (c + r) % 6);
      end
    v6 = 1'b1; m6 = 2'b00; s6 = in6;
    @(negedge clk);
    v6 = 1'b0;
    chk("nb6_valid", ov6, 1);
    chk("nb6_fwd", os6, e6);
    chk("nb6_row3_c5", os6[191-(4*5+3)*8 -: 8], 8'd26);
    @(negedge clk);
    chk("nb6_drained", ov6, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
